pmemory: RTL
============

# pmemory

Parametrised single-port synchronous memory; successor to the fixed 16x32 memory block. Adds configurable data width, depth and read latency, a request/ready handshake, byte-enable writes, out-of-range address detection and an optional post-reset clearing sweep. Sits behind a bus agent or a test sequencer as a generic storage target for the UVM environment.

## Interface
- DATA_W, 32: data width in bits; multiple of 8.
- DEPTH, 16: number of words; need not be a power of two (≥2).
- RD_LAT, 1: read latency in cycles, legal 1..4.
- ADDR_W, derived localparam: $clog2(DEPTH).
- BE_W, derived localparam: DATA_W/8.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req  in  1  request valid.
- i_we  in  1  1 = write, 0 = read; sampled with i_req.
- i_address  in  ADDR_W  word address.
- i_data_in  in  DATA_W  write data.
- i_be  in  BE_W  byte enables; bit k gates byte k on writes, ignored on reads.
- o_ready  out  1  block accepts a request this cycle.
- o_data_out  out  DATA_W  read data, meaningful only while o_valid=1.
- o_valid  out  1  single-cycle read-data pulse.
- o_err  out  1  single-cycle pulse for an out-of-range access.
- o_init_done  out  1  high once the block is operational; stays high until next reset.

## Operation
- Request accepted on a rising edge where i_req & o_ready. One request per cycle maximum; no backpressure on the output side.
- FSM states: INIT, READY.
  - INIT: internal counter 0..DEPTH-1 writes all-zero to one word per cycle; o_ready=0; requests ignored (not queued).
  - INIT → READY after writing word DEPTH-1. READY is terminal until reset.
- Write (i_we=1): bytes with i_be[k]=1 updated; other bytes retain their value. i_be=0 is a legal no-op write.
- Read (i_we=0): word enters a RD_LAT-deep pipeline carrying {valid, data, err}.
- Out-of-range (i_address ≥ DEPTH):
  - write: array untouched, o_err pulses in the next cycle.
  - read: o_valid and o_err pulse together, o_data_out = 0.
- Read of an address written in the immediately preceding accepted cycle returns the new data.
- Reset asserted mid-operation: pipeline flushed, in-flight reads discarded (no o_valid), FSM back to INIT.

## Timing
- Reset values: o_ready=0, o_data_out=0, o_valid=0, o_err=0, o_init_done=0.
- With clearing enabled, after reset release: o_ready and o_init_done rise after DEPTH clock edges (DEPTH=16 → high after edge 16).
- Read accepted at edge N → o_valid=1 and data valid in the cycle after edge N+RD_LAT-1, i.e. RD_LAT edges after acceptance.
  - RD_LAT=1 matches the previous generation's timing.
- Back-to-back reads give back-to-back o_valid pulses in order.
- o_valid is a pulse and is 0 after writes and in idle cycles; it is not held high.
- o_data_out holds its last value when o_valid=0.
- o_ready stays 1 in READY regardless of pipeline occupancy.

## Configuration
- PMEM_INIT_CLEAR_EN defined: INIT sweep as above; every word reads 0 until written.
- PMEM_INIT_CLEAR_EN undefined:
  - no INIT state or counter.
  - o_ready and o_init_done go high on the first rising edge after reset release.
  - Contents are undefined until written; unwritten reads return X in simulation.

## Structure
- pmem_pkg holds:
  - typedef enum logic {INIT, READY} pmem_state_e.
  - RD_LAT_MAX = 4.
  - a function computing the byte-merge of old data, new data and enables.
- Sub-module pmem_rd_pipe (params DATA_W, RD_LAT): shift register of {valid, err, data} with async reset clearing the valid and err bits.
- Top holds the array, FSM, init counter and range check.

## Test plan
- Reset release with PMEM_INIT_CLEAR_EN, DEPTH=16: o_ready=0 for 16 edges, then 1; reads of addresses 0..15 return 0x0000_0000.
- Write 0xDEADBEEF to address 3 with i_be=4'b1111, then read address 3 with i_be=4'b0101 write 0x11223344 in between: read returns 0xDE22BE44.
- RD_LAT=3: four back-to-back reads of addresses 0..3 pre-loaded with 0xA..0xD → o_valid for 4 consecutive cycles starting 3 edges after the first acceptance, data A,B,C,D in order.
- DEPTH=12: read of address 13 → o_valid=o_err=1 with data 0. Write to address 14 → o_err pulse next cycle, and no word changes.
- Write 0x5 to address 7 at edge N, read address 7 at edge N+1 → returns 0x5.
- Assert i_rst_n=0 with two reads in flight → no o_valid afterwards, all outputs 0, and the INIT sweep restarts on release.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types, limits and the byte-merge helper used by pmemory.
package pmem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } pmem_state_e;

    localparam int RD_LAT_MAX = 4;

    // One byte lane of a masked write: take the new byte only when its enable is set.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/pmem_rd_pipe.sv
// Read-return shift register of {valid, err, data}, RD_LAT stages deep.
// The last stage only reloads data on a valid beat so the output holds between reads.
module pmem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic              valid_reg;
            logic              err_reg;
            logic [DATA_W-1:0] data_reg;
            logic              valid_prev;
            logic              err_prev;
            logic [DATA_W-1:0] data_prev;

            if (gi == 0) begin : g_head
                assign valid_prev = in_valid;
                assign err_prev   = in_err;
                assign data_prev  = in_data;
            end else begin : g_body
                assign valid_prev = g_stage[gi-1].valid_reg;
                assign err_prev   = g_stage[gi-1].err_reg;
                assign data_prev  = g_stage[gi-1].data_reg;
            end

            // Data is cleared as well so the visible read data is 0 out of reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= valid_prev;
                    err_reg   <= err_prev;
                    if ((gi != RD_LAT - 1) || valid_prev) begin
                        data_reg <= data_prev;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[RD_LAT-1].valid_reg;
    assign out_err   = g_stage[RD_LAT-1].err_reg;
    assign out_data  = g_stage[RD_LAT-1].data_reg;

endmodule

// File: rtl/pmemory.sv
// Parametrised single-port memory with byte enables, range check and RD_LAT read pipeline.
// Define PMEM_INIT_CLEAR_EN to zero every word in an INIT sweep after reset.
module pmemory
    import pmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic [BE_W-1:0]   i_be,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_valid,
    output logic              o_err,
    output logic              o_init_done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_err_reg;
    logic              pipe_err;

    assign in_range = ({1'b0, i_address} < DEPTH_L);
    assign accept   = i_req & ready;
    assign rd_word  = in_range ? mem[i_address] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_merge
            assign wr_word[gi*8 +: 8] = merge_byte(rd_word[gi*8 +: 8], i_data_in[gi*8 +: 8], i_be[gi]);
        end
    endgenerate

`ifdef PMEM_INIT_CLEAR_EN
    localparam logic [ADDR_W:0] LAST_L = (ADDR_W + 1)'(DEPTH - 1);

    pmem_state_e       state_reg;
    pmem_state_e       state_next;
    logic [ADDR_W-1:0] init_cnt_reg;
    logic [ADDR_W-1:0] init_cnt_next;
    logic              clear_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        clear_we      = 1'b0;
        case (state_reg)
            INIT: begin
                clear_we = 1'b1;
                if ({1'b0, init_cnt_reg} == LAST_L) begin
                    state_next = READY;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            READY: begin
                state_next = READY;
            end
        endcase
    end

    assign ready = (state_reg == READY);

    // The sweep owns the write port while INIT; no request can be accepted then.
    always_comb begin
        mem_we    = accept & i_we & in_range;
        mem_addr  = i_address;
        mem_wdata = wr_word;
        if (clear_we) begin
            mem_we    = 1'b1;
            mem_addr  = init_cnt_reg;
            mem_wdata = '0;
        end
    end
`else
    logic ready_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign ready     = ready_reg;
    assign mem_we    = accept & i_we & in_range;
    assign mem_addr  = i_address;
    assign mem_wdata = wr_word;
`endif

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= accept & i_we & ~in_range;
        end
    end

    pmem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .in_valid  (accept & ~i_we),
        .in_err    (accept & ~i_we & ~in_range),
        .in_data   (rd_word),
        .out_valid (o_valid),
        .out_err   (pipe_err),
        .out_data  (o_data_out)
    );

    assign o_err       = pipe_err | wr_err_reg;
    assign o_ready     = ready;
    assign o_init_done = ready;

endmodule
